// File: rtl/arrow_slot_scheduler.sv
// arrow_slot_scheduler
//   Owns a pool of NUM_SLOTS arrow sprite slots for a 4-lane playfield.
//   Once per frame (rising edge of frame_clk) every live arrow scrolls up by
//   SPEED, arrows past the receptor window expire, and the per-lane spawn
//   requests are allocated to the lowest free slots. Per-lane hit pulses are
//   queued and judged between frames against the receptor window.
//
//   Ports
//     Clk, Reset          clock, asynchronous active-high reset
//     frame_clk           VGA_VS, rising edge = frame tick
//     spawn_req[3:0]      per-lane spawn request (sampled in SPAWNk)
//     hit[3:0]            per-lane keypress pulse
//     slot_valid/lane/y   flattened per-slot state for the renderer
//     judge_hit, hit_lane judged hit pulse and its (held) lane
//     judge_miss,miss_num expiry pulse and number expired that frame
//     overflow            spawn dropped, no free slot
//     busy                state machine not idle
//     hit_count,miss_count statistics counters
//
//   Optional: define ARROW_SCHED_STATS_EN to enable the saturating
//   hit/miss counters; otherwise both read 0.
module arrow_slot_scheduler #(
  parameter int NUM_SLOTS  = 8,
  parameter int SPEED      = 4,
  parameter int START_Y    = 480,
  parameter int RECEPTOR_Y = 48,
  parameter int HIT_WIN    = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_clk,
  input  logic [3:0]                     spawn_req,
  input  logic [3:0]                     hit,
  output logic [NUM_SLOTS-1:0]           slot_valid,
  output logic [2*NUM_SLOTS-1:0]         slot_lane,
  output logic [10*NUM_SLOTS-1:0]        slot_y,
  output logic                           judge_hit,
  output logic [1:0]                     hit_lane,
  output logic                           judge_miss,
  output logic [$clog2(NUM_SLOTS+1)-1:0] miss_num,
  output logic                           overflow,
  output logic                           busy,
  output logic [15:0]                    hit_count,
  output logic [15:0]                    miss_count
);

  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam int IW = $clog2(NUM_SLOTS);
  localparam logic [9:0] EXPIRE_Y = 10'(RECEPTOR_Y - HIT_WIN + SPEED);
  localparam logic [9:0] WIN_LO   = 10'(RECEPTOR_Y - HIT_WIN);
  localparam logic [9:0] WIN_HI   = 10'(RECEPTOR_Y + HIT_WIN);
  localparam logic [9:0] STEP     = 10'(SPEED);
  localparam logic [9:0] SPAWN_Y  = 10'(START_Y);

  typedef enum logic [2:0] {
    IDLE, ADVANCE, SPAWN0, SPAWN1, SPAWN2, SPAWN3, JUDGE
  } state_t;

  state_t          state_q, state_d;
  logic            frame_q;
  logic            tick_pend_q, tick_pend_d;
  logic [3:0]      hit_pend_q, hit_pend_d;
  logic [1:0]      tgt_q, tgt_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [1:0]      lane_q [NUM_SLOTS];
  logic [1:0]      lane_d [NUM_SLOTS];
  logic [9:0]      y_q    [NUM_SLOTS];
  logic [9:0]      y_d    [NUM_SLOTS];
  logic            judge_hit_q, judge_hit_d;
  logic [1:0]      hit_lane_q, hit_lane_d;
  logic            judge_miss_q, judge_miss_d;
  logic [CW-1:0]   miss_num_q, miss_num_d;
  logic            overflow_q, overflow_d;

  logic            tick;
  logic [1:0]      sp_lane;
  state_t          sp_next;
  logic [CW-1:0]   exp_cnt;
  logic            free_found, cand_found;
  logic [IW-1:0]   free_idx, cand_idx;
  logic [9:0]      cand_y;

  assign tick = frame_clk & ~frame_q;

  always_comb begin
    sp_lane = 2'd0;
    sp_next = IDLE;
    case (state_q)
      SPAWN0:  begin sp_lane = 2'd0; sp_next = SPAWN1; end
      SPAWN1:  begin sp_lane = 2'd1; sp_next = SPAWN2; end
      SPAWN2:  begin sp_lane = 2'd2; sp_next = SPAWN3; end
      SPAWN3:  begin sp_lane = 2'd3; sp_next = IDLE;   end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tick_pend_d  = tick_pend_q | tick;
    hit_pend_d   = hit_pend_q | hit;
    tgt_d        = tgt_q;
    valid_d      = valid_q;
    lane_d       = lane_q;
    y_d          = y_q;
    judge_hit_d  = 1'b0;
    hit_lane_d   = hit_lane_q;
    judge_miss_d = 1'b0;
    miss_num_d   = miss_num_q;
    overflow_d   = 1'b0;
    exp_cnt      = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    cand_found   = 1'b0;
    cand_idx     = '0;
    cand_y       = '1;

    unique case (state_q)
      IDLE: begin
        if (tick_pend_q) begin
          state_d     = ADVANCE;
          // a tick landing in this very cycle stays pending for next frame
          tick_pend_d = tick;
        end else if (hit_pend_q != 4'b0000) begin
          state_d = JUDGE;
          if (hit_pend_q[0])      tgt_d = 2'd0;
          else if (hit_pend_q[1]) tgt_d = 2'd1;
          else if (hit_pend_q[2]) tgt_d = 2'd2;
          else                    tgt_d = 2'd3;
        end
      end
      ADVANCE: begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (valid_q[i]) begin
            // expiry test precedes the subtraction so y cannot wrap
            if (y_q[i] < EXPIRE_Y) begin
              valid_d[i] = 1'b0;
              exp_cnt    = exp_cnt + CW'(1);
            end else begin
              y_d[i] = y_q[i] - STEP;
            end
          end
        end
        judge_miss_d = (exp_cnt != '0);
        miss_num_d   = exp_cnt;
        state_d      = SPAWN0;
      end
      SPAWN0, SPAWN1, SPAWN2, SPAWN3: begin
        if (spawn_req[sp_lane]) begin
          // descending scan leaves the lowest free index selected
          for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
            if (!valid_q[i-1]) begin
              free_found = 1'b1;
              free_idx   = IW'(i - 1);
            end
          end
          if (free_found) begin
            valid_d[free_idx] = 1'b1;
            lane_d[free_idx]  = sp_lane;
            y_d[free_idx]     = SPAWN_Y;
          end else begin
            overflow_d = 1'b1;
          end
        end
        state_d = sp_next;
      end
      JUDGE: begin
        // strict < keeps the lowest index on equal y
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (valid_q[i] && lane_q[i] == tgt_q && y_q[i] >= WIN_LO &&
              y_q[i] <= WIN_HI && (!cand_found || y_q[i] < cand_y)) begin
            cand_found = 1'b1;
            cand_idx   = IW'(i);
            cand_y     = y_q[i];
          end
        end
        if (cand_found) begin
          valid_d[cand_idx] = 1'b0;
          judge_hit_d       = 1'b1;
          hit_lane_d        = tgt_q;
        end
        // a new press arriving during service is kept, not swallowed
        hit_pend_d[tgt_q] = hit[tgt_q];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      frame_q      <= 1'b0;
      tick_pend_q  <= 1'b0;
      hit_pend_q   <= '0;
      tgt_q        <= '0;
      valid_q      <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        lane_q[i] <= '0;
        y_q[i]    <= '0;
      end
      judge_hit_q  <= 1'b0;
      hit_lane_q   <= '0;
      judge_miss_q <= 1'b0;
      miss_num_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_clk;
      tick_pend_q  <= tick_pend_d;
      hit_pend_q   <= hit_pend_d;
      tgt_q        <= tgt_d;
      valid_q      <= valid_d;
      lane_q       <= lane_d;
      y_q          <= y_d;
      judge_hit_q  <= judge_hit_d;
      hit_lane_q   <= hit_lane_d;
      judge_miss_q <= judge_miss_d;
      miss_num_q   <= miss_num_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    slot_lane = '0;
    slot_y    = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_lane[2*i +: 2]  = lane_q[i];
      slot_y[10*i +: 10]   = y_q[i];
    end
  end

  assign slot_valid = valid_q;
  assign judge_hit  = judge_hit_q;
  assign hit_lane   = hit_lane_q;
  assign judge_miss = judge_miss_q;
  assign miss_num   = miss_num_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

`ifdef ARROW_SCHED_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic [16:0] miss_sum;

  assign miss_sum = {1'b0, miss_cnt_q} + 17'(miss_num_q);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (judge_hit_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (judge_miss_q) miss_cnt_q <= miss_sum[16] ? '1 : miss_sum[15:0];
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_arrow_slot_scheduler.sv
// Self-checking bench for arrow_slot_scheduler: directed scenarios followed by
// randomized frames/hits, all compared against a frame-level reference model.
module tb_arrow_slot_scheduler;

  localparam int NS     = 8;
  localparam int SPD    = 4;
  localparam int STY    = 480;
  localparam int RCP    = 48;
  localparam int WIN    = 16;
  localparam int EXP_TH = RCP - WIN + SPD;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            frame_clk = 1'b0;
  logic [3:0]      spawn_req = '0;
  logic [3:0]      hit = '0;
  logic [NS-1:0]   slot_valid;
  logic [2*NS-1:0] slot_lane;
  logic [10*NS-1:0] slot_y;
  logic            judge_hit;
  logic [1:0]      hit_lane;
  logic            judge_miss;
  logic [3:0]      miss_num;
  logic            overflow;
  logic            busy;
  logic [15:0]     hit_count;
  logic [15:0]     miss_count;

  arrow_slot_scheduler #(
    .NUM_SLOTS(NS), .SPEED(SPD), .START_Y(STY), .RECEPTOR_Y(RCP), .HIT_WIN(WIN)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .spawn_req(spawn_req),
    .hit(hit), .slot_valid(slot_valid), .slot_lane(slot_lane), .slot_y(slot_y),
    .judge_hit(judge_hit), .hit_lane(hit_lane), .judge_miss(judge_miss),
    .miss_num(miss_num), .overflow(overflow), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  bit m_v    [NS];
  int m_lane [NS];
  int m_y    [NS];
  int m_hitlane = 0;
  int m_hits    = 0;
  int m_misses  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < NS; i++) begin
      m_v[i] = 1'b0; m_lane[i] = 0; m_y[i] = 0;
    end
    m_hitlane = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic m_frame(input logic [3:0] req, output int nmiss, output int novf);
    nmiss = 0; novf = 0;
    for (int i = 0; i < NS; i++)
      if (m_v[i]) begin
        if (m_y[i] < EXP_TH) begin m_v[i] = 1'b0; nmiss++; end
        else m_y[i] -= SPD;
      end
    for (int k = 0; k < 4; k++)
      if (req[k]) begin
        int slot = -1;
        for (int i = NS - 1; i >= 0; i--) if (!m_v[i]) slot = i;
        if (slot < 0) novf++;
        else begin m_v[slot] = 1'b1; m_lane[slot] = k; m_y[slot] = STY; end
      end
    m_misses += nmiss;
  endtask

  task automatic m_hit(input int ln, output bit ok);
    int best = -1;
    for (int i = 0; i < NS; i++)
      if (m_v[i] && m_lane[i] == ln && m_y[i] >= RCP - WIN && m_y[i] <= RCP + WIN &&
          (best < 0 || m_y[i] < m_y[best]))
        best = i;
    ok = (best >= 0);
    if (ok) begin m_v[best] = 1'b0; m_hitlane = ln; m_hits++; end
  endtask

  task automatic check_state();
    logic [9:0] yv;
    logic [1:0] lv;
    for (int i = 0; i < NS; i++) begin
      check_eq($sformatf("valid%0d", i), {31'b0, slot_valid[i]}, {31'b0, m_v[i]});
      if (m_v[i]) begin
        lv = slot_lane[2*i +: 2];
        yv = slot_y[10*i +: 10];
        check_eq($sformatf("lane%0d", i), {30'b0, lv}, m_lane[i]);
        check_eq($sformatf("y%0d", i), {22'b0, yv}, m_y[i]);
      end
    end
    check_eq("hit_lane", {30'b0, hit_lane}, m_hitlane);
`ifdef ARROW_SCHED_STATS_EN
    check_eq("hit_count", {16'b0, hit_count}, (m_hits > 65535) ? 65535 : m_hits);
    check_eq("miss_count", {16'b0, miss_count}, (m_misses > 65535) ? 65535 : m_misses);
`else
    check_eq("hit_count", {16'b0, hit_count}, 0);
    check_eq("miss_count", {16'b0, miss_count}, 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; hit = '0; spawn_req = '0;
    #1;
    check_eq("rst_valid", {24'b0, slot_valid}, 0);
    check_eq("rst_y_any", {31'b0, |slot_y}, 0);
    check_eq("rst_lane_any", {31'b0, |slot_lane}, 0);
    check_eq("rst_pulses", {28'b0, judge_hit, judge_miss, overflow, busy}, 0);
    check_eq("rst_hit_lane", {30'b0, hit_lane}, 0);
    check_eq("rst_miss_num", {28'b0, miss_num}, 0);
    check_eq("rst_counts", {hit_count, miss_count}, 0);
    @(negedge Clk);
    Reset = 1'b0;
    m_clear();
  endtask

  // One frame tick with spawn requests; optionally a hit on lane hl in the
  // same cycle as the frame_clk edge (hl < 0 for none).
  task automatic run_frame(input logic [3:0] req, input int hl);
    int mp = 0, msum = 0, ovf = 0, nh = 0, hit_at = -1, nm, no;
    bit ok = 1'b0;
    @(negedge Clk);
    spawn_req = req; frame_clk = 1'b1;
    if (hl >= 0) hit = 4'b0001 << hl;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (judge_miss) begin mp++; msum += int'(miss_num); end
      if (overflow) ovf++;
      if (judge_hit) begin nh++; if (hit_at < 0) hit_at = c; end
      if (c == 5) check_eq("busy_spawn3", {31'b0, busy}, 1);
      if (c == 6) check_eq("busy_done6", {31'b0, busy}, 0);
      if (c == 0) hit = '0;
      if (c == 3) frame_clk = 1'b0;
    end
    spawn_req = '0;
    m_frame(req, nm, no);
    if (hl >= 0) m_hit(hl, ok);
    check_eq("miss_pulses", mp, (nm > 0) ? 1 : 0);
    check_eq("miss_num", msum, nm);
    check_eq("overflow_cnt", ovf, no);
    check_eq("frame_hits", nh, ok ? 1 : 0);
    if (hl >= 0) check_eq("tick_hit_lat", hit_at, ok ? 8 : -1);
    check_state();
  endtask

  task automatic run_hit(input int ln);
    int nh = 0, hit_at = -1;
    bit ok;
    @(negedge Clk);
    hit = 4'b0001 << ln;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (judge_hit) begin nh++; if (hit_at < 0) hit_at = c; end
      if (c == 0) hit = '0;
    end
    m_hit(ln, ok);
    check_eq("hit_pulses", nh, ok ? 1 : 0);
    check_eq("hit_latency", hit_at, ok ? 2 : -1);
    check_state();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_clear();
    // first spawn after reset
    do_reset();
    run_frame(4'b0010, -1);

    // pool fill, lane order, overflow, scroll
    do_reset();
    repeat (9) run_frame(4'b1111, -1);
    check_eq("fill_y448", {22'b0, slot_y[9:0]}, 448);

    // hit exactly at the receptor
    do_reset();
    run_frame(4'b0100, -1);
    repeat (108) run_frame(4'b0000, -1);
    check_eq("pre_hit_y48", {22'b0, slot_y[9:0]}, 48);
    run_hit(2);
    check_eq("hit_lane2", {30'b0, hit_lane}, 2);

    // single expiry, then a two-arrow expiry in the same frame
    do_reset();
    run_frame(4'b0001, -1);
    run_frame(4'b0011, -1);
    repeat (114) run_frame(4'b0000, -1);

    // hit coincident with the frame edge is serviced after frame work
    do_reset();
    run_frame(4'b1000, -1);
    repeat (106) run_frame(4'b0000, -1);
    run_frame(4'b0000, 3);

    // reset in the middle of SPAWN1 with five live slots
    do_reset();
    run_frame(4'b1111, -1);
    run_frame(4'b0001, -1);
    @(negedge Clk);
    frame_clk = 1'b1; spawn_req = 4'b1111;
    repeat (4) @(negedge Clk);
    check_eq("busy_mid_frame", {31'b0, busy}, 1);
    do_reset();
    run_frame(4'b0010, -1);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        logic [3:0] rq;
        int hl;
        rq = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        hl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
        run_frame(rq, hl);
      end else begin
        run_hit(int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
